// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, RTS, 11-bit frame, ACK check).
// Define PS2_TX_TIMEOUT_EN to abort a transfer that stalls for TIMEOUT_CYCLES after RTS.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);
    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} state_t;
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    state_t        state_q, state_d;
    logic [8:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [IW-1:0] inh_cnt_q, inh_cnt_d;
    logic [1:0]    clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic          clk_prev_q, clk_prev_d;
    logic          clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
    logic          done_q, done_d, err_q, err_d, ready_q, ready_d;
    logic          clk_s, dat_s, fall;
`ifdef PS2_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timing;
`endif
    assign clk_s      = clk_sync_q[1];
    assign dat_s      = dat_sync_q[1];
    assign fall       = clk_prev_q & ~clk_s;
    assign tx_ready   = ready_q;
    assign tx_done    = done_q;
    assign tx_error   = err_q;
    assign busy       = state_q != IDLE;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk_in};
        dat_sync_d = {dat_sync_q[0], ps2_dat_in};
        clk_prev_d = clk_s;
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        inh_cnt_d  = inh_cnt_q;
        clk_oe_d   = clk_oe_q;
        dat_oe_d   = dat_oe_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: if (tx_valid && ready_q) begin
                shift_d   = {~^tx_data, tx_data};
                inh_cnt_d = '0;
                bit_cnt_d = '0;
                clk_oe_d  = 1'b1;
                state_d   = INHIBIT;
            end
            INHIBIT: if (inh_cnt_q == INH_LAST) begin
                dat_oe_d = 1'b1;
                state_d  = RTS;
            end else begin
                inh_cnt_d = inh_cnt_q + 1'b1;
            end
            RTS: begin
                clk_oe_d  = 1'b0;
                bit_cnt_d = '0;
                state_d   = SEND;
            end
            SEND: if (fall) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == 4'd9) begin
                    dat_oe_d = 1'b0;
                    state_d  = ACK;
                end else begin
                    dat_oe_d = ~shift_q[0];
                    shift_d  = shift_q >> 1;
                end
            end
            ACK: if (fall) begin
                err_d   = dat_s;
                state_d = dat_s ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: if (clk_s && dat_s) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        // The timeout wins over any line event seen in the same cycle.
        timing   = state_q inside {RTS, SEND, ACK, WAIT_IDLE};
        to_cnt_d = timing ? to_cnt_q + 1'b1 : '0;
        if (timing && to_cnt_q == TO_LAST) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            done_d   = 1'b0;
            err_d    = 1'b1;
            state_d  = IDLE;
        end
`endif
        ready_d = state_d == IDLE && !done_d && !err_d;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            inh_cnt_q  <= '0;
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b1;
`ifdef PS2_TX_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            inh_cnt_q  <= inh_cnt_d;
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
`ifdef PS2_TX_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a clocking PS/2 device model.
module tb_ps2_host_tx;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    typedef struct packed {
        logic [10:0] bits;
        logic        chk_bits;
        logic        err;
    } exp_t;
    exp_t        exp_q[$];
    logic [10:0] cap;
    int          n_chk = 0, n_fail = 0, n_done = 0, n_err = 0;
    int          cyc = 0, run = 0, ov = 0, last_run = 0, last_ov = 0;
    int          rts_cyc = 0, err_cyc = 0;
    logic [1:0]  err_oe;
    logic        dat_prev = 1'b0;

    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(.INHIBIT_CYCLES(5000), .TIMEOUT_CYCLES(2000)) dut (
        .clk(clk), .resetn(resetn), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error), .busy(busy),
        .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inhibit-length and RTS-overlap measurement, plus the pulse scoreboard.
    always @(negedge clk) begin
        if (ps2_clk_oe) begin
            run++;
            if (ps2_dat_oe) ov++;
        end else if (run > 0) begin
            last_run = run;
            last_ov  = ov;
            run = 0;
            ov  = 0;
        end
        if (ps2_dat_oe && !dat_prev && ps2_clk_oe) rts_cyc = cyc;
        dat_prev = ps2_dat_oe;
        if (resetn && (tx_done || tx_error)) begin
            exp_t e;
            chk("done_err_exclusive", {31'b0, tx_done & tx_error}, 0);
            chk("ready_low_in_pulse", {31'b0, tx_ready}, 0);
            if (tx_done) n_done++;
            if (tx_error) begin
                n_err++;
                err_cyc = cyc;
                err_oe  = {ps2_clk_oe, ps2_dat_oe};
            end
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {31'b0, tx_error}, {31'b0, ~tx_error});
            end else begin
                e = exp_q.pop_front();
                chk("pulse_is_error", {31'b0, tx_error}, {31'b0, e.err});
                if (e.chk_bits) chk("frame_bits", {21'b0, cap}, {21'b0, e.bits});
            end
        end
    end

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("busy_after_accept", {30'b0, busy, tx_ready}, 2'b10);
    endtask

    task automatic dev_run(input int pulses, input bit ack);
        int n;
        cap = '0;
        n = 0;
        while (!ps2_clk_oe && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (ps2_clk_oe && n < 6000) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        for (int k = 0; k < pulses; k++) begin
            cap[k] = ps2_dat_in;
            if (k == 10 && ack) begin
                dev_dat_low = 1'b1;
                repeat (2) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k == 10) begin
                repeat (5) @(negedge clk);
                dev_dat_low = 1'b0;
            end
            repeat (20) @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!tx_ready && n < budget) begin @(negedge clk); n++; end
        chk("returned_to_idle", {31'b0, tx_ready}, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("reset_ready", {31'b0, tx_ready}, 1);
        chk("reset_busy", {31'b0, busy}, 0);
        chk("reset_oe", {30'b0, ps2_clk_oe, ps2_dat_oe}, 0);
        chk("reset_pulses", {30'b0, tx_done, tx_error}, 0);

        // 0xED, ACKed: start 0, 1,0,1,1,0,1,1,1, parity 1, stop 1
        exp_q.push_back('{11'b1_1_11101101_0, 1'b1, 1'b0});
        fork send(8'hED); dev_run(11, 1'b1); join
        wait_idle(200);
        chk("inhibit_len", last_run, 5001);
        chk("rts_overlap", last_ov, 1);

        // 0xFF, NACKed: parity 1, error pulse only
        exp_q.push_back('{11'b1_1_11111111_0, 1'b1, 1'b1});
        fork send(8'hFF); dev_run(11, 1'b0); join
        wait_idle(200);
        chk("nack_state_idle", {31'b0, busy}, 0);

`ifdef PS2_TX_TIMEOUT_EN
        exp_q.push_back('{11'b0, 1'b0, 1'b1});
        send(8'hED);
        wait_idle(10000);
        chk("timeout_latency", err_cyc - rts_cyc, 2000);
        chk("timeout_oe_released", {30'b0, err_oe}, 0);
`endif

        // Reset after data bit 4 of 0xC3 (bit 4 = 0, so data is held low)
        fork send(8'hC3); dev_run(5, 1'b0); join
        chk("bit4_driven_low", {31'b0, ps2_dat_oe}, 1);
        resetn = 1'b0;
        @(negedge clk);
        chk("reset_mid_oe", {30'b0, ps2_clk_oe, ps2_dat_oe}, 0);
        chk("reset_mid_pulses", {30'b0, tx_done, tx_error}, 0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_mid_ready", {31'b0, tx_ready}, 1);

        // 0x00 after the aborted transfer: parity 1
        exp_q.push_back('{11'b1_1_00000000_0, 1'b1, 1'b0});
        fork send(8'h00); dev_run(11, 1'b1); join
        wait_idle(200);

        // 0x55 offered while 0xAA is in flight must be ignored
        exp_q.push_back('{11'b1_1_10101010_0, 1'b1, 1'b0});
        fork
            begin
                send(8'hAA);
                repeat (50) @(negedge clk);
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                repeat (100) @(negedge clk);
                tx_valid = 1'b0;
            end
            dev_run(11, 1'b1);
        join
        wait_idle(200);
        repeat (50) @(negedge clk);
        chk("no_queued_send", {31'b0, busy}, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        chk("done_count", n_done, 3);
`ifdef PS2_TX_TIMEOUT_EN
        chk("error_count", n_err, 2);
`else
        chk("error_count", n_err, 1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_800_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
